// File: rtl/td4_execute_if.sv
// Fetch/execute link of the TD4 core: instruction forward, jump request back.
// Purely combinational wires; no latency of its own.
// No backpressure: fetch presents one instruction every clk.
interface td4_execute_if #(
  parameter int W = 4
);
  logic [2*W-1:0] inst;
  logic           isjump;
  logic [W-1:0]   jumpadrs;

  // Fetch drives the instruction and consumes the jump request.
  modport master (output inst, input isjump, jumpadrs);
  // Execute consumes the instruction and drives the jump request.
  modport slave  (input inst, output isjump, jumpadrs);
endinterface

// File: rtl/td4_execute.sv
// Execute stage of the TD4 core: A, B, OUT and carry state plus jump decode.
// State updates one clk after the instruction; jump request is combinational.
// No backpressure: one instruction is retired every clk.
module td4_execute #(
  parameter int           W       = 4,
  parameter logic [W-1:0] OUT_RST = '0
) (
  input  logic          clk,
  input  logic          rst,
  td4_execute_if.slave  fetch,
  input  logic [W-1:0]  in_port,
  output logic [W-1:0]  out_port,
  output logic [W-1:0]  reg_a,
  output logic [W-1:0]  reg_b,
  output logic          carry
);

  localparam logic [W-1:0] OP_ADD_A  = W'(4'b0000);
  localparam logic [W-1:0] OP_MOV_AB = W'(4'b0001);
  localparam logic [W-1:0] OP_IN_A   = W'(4'b0010);
  localparam logic [W-1:0] OP_MOV_AI = W'(4'b0011);
  localparam logic [W-1:0] OP_MOV_BA = W'(4'b0100);
  localparam logic [W-1:0] OP_ADD_B  = W'(4'b0101);
  localparam logic [W-1:0] OP_IN_B   = W'(4'b0110);
  localparam logic [W-1:0] OP_MOV_BI = W'(4'b0111);
  localparam logic [W-1:0] OP_OUT_B  = W'(4'b1001);
  localparam logic [W-1:0] OP_OUT_I  = W'(4'b1011);
  localparam logic [W-1:0] OP_JNC    = W'(4'b1110);
  localparam logic [W-1:0] OP_JMP    = W'(4'b1111);

  logic [W-1:0] op;
  logic [W-1:0] imm;
  logic [W:0]   sum_a;
  logic [W:0]   sum_b;
  logic [W-1:0] a_nxt;
  logic [W-1:0] b_nxt;
  logic [W-1:0] out_nxt;
  logic         c_nxt;

  assign op    = fetch.inst[2*W-1:W];
  assign imm   = fetch.inst[W-1:0];
  assign sum_a = {1'b0, reg_a} + {1'b0, imm};
  assign sum_b = {1'b0, reg_b} + {1'b0, imm};

  // Jump request: JNC looks at the carry left by the previous instruction.
  always_comb begin
    fetch.isjump   = 1'b0;
    fetch.jumpadrs = imm;
    if (!rst) begin
      fetch.isjump = (op == OP_JMP) || ((op == OP_JNC) && !carry);
    end
  end

  // Next architectural state; carry is cleared by everything except ADD.
  always_comb begin
    a_nxt   = reg_a;
    b_nxt   = reg_b;
    out_nxt = out_port;
    c_nxt   = 1'b0;
    case (op)
      OP_ADD_A:  {c_nxt, a_nxt} = sum_a;
      OP_ADD_B:  {c_nxt, b_nxt} = sum_b;
      OP_MOV_AI: a_nxt = imm;
      OP_MOV_BI: b_nxt = imm;
      OP_MOV_AB: a_nxt = reg_b;
      OP_MOV_BA: b_nxt = reg_a;
      OP_IN_A:   a_nxt = in_port;
      OP_IN_B:   b_nxt = in_port;
      OP_OUT_B:  out_nxt = reg_b;
      OP_OUT_I:  out_nxt = imm;
      default:   ;
    endcase
  end

  // State register; reset overrides whatever instruction is present.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a    <= '0;
      reg_b    <= '0;
      out_port <= OUT_RST;
      carry    <= 1'b0;
    end else begin
      reg_a    <= a_nxt;
      reg_b    <= b_nxt;
      out_port <= out_nxt;
      carry    <= c_nxt;
    end
  end

endmodule
